muladd_seq: RTL

Sequential unsigned multiply-accumulate unit computing y = q × d + r over WIDTH-bit operands with a 2×WIDTH-bit result. It is the inverse of the FPU's iterative integer divider: it rebuilds the dividend from a quotient, divisor and remainder, so it serves both as a mantissa multiplier and as an in-circuit divider checker. It uses the same start/done handshake as the divider: a one-cycle `en` start pulse and a one-cycle `calc_done` completion pulse. It uses one shift-add iteration per cycle with fixed latency.

---
 rtl/muladd_seq.sv | 116 +++++++++++
 1 files changed

// File: rtl/muladd_seq.sv
// Sequential unsigned multiply-accumulate: y = q * d + r, one shift-add step per cycle.
// Latency: WIDTH+1 cycles from accepted en to the calc_done pulse (33 for WIDTH=32).
// Backpressure: none; en is only accepted while idle (busy=0), otherwise dropped.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset; aborts any running operation
//   en         start pulse, sampled only while idle
//   q, d, r    multiplier, multiplicand and addend, captured with an accepted en
//   y          2*WIDTH-bit result, held until the next completion or reset
//   ovf        result does not fit in WIDTH bits, updated together with y
//   busy       high whenever an operation is in flight
//   calc_done  one-cycle pulse in the cycle y/ovf are updated
module muladd_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH-1:0]   r,
  output logic [2*WIDTH-1:0] y,
  output logic               ovf,
  output logic               busy,
  output logic               calc_done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic load;
  logic step;
  logic finish;
  logic last_iter;

  // The final iteration is the one that runs with cnt = WIDTH-1; there is no
  // early exit, so latency does not depend on the operand values.
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en)        state_nxt = ST_CALC;
      ST_CALC: if (last_iter) state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    busy   = (state != ST_IDLE);
    load   = (state == ST_IDLE) && en;
    step   = (state == ST_CALC);
    finish = (state == ST_DONE);
  end

  // Datapath. The accumulator is 2*WIDTH bits wide; (2^W-1)^2 + (2^W-1) still
  // fits, so the add never carries out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      y         <= '0;
      ovf       <= 1'b0;
      calc_done <= 1'b0;
    end else begin
      calc_done <= 1'b0;
      if (load) begin
        mcand  <= {{WIDTH{1'b0}}, d};
        mplier <= q;
        acc    <= {{WIDTH{1'b0}}, r};
        cnt    <= '0;
      end
      if (step) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      if (finish) begin
        y         <= acc;
        ovf       <= |acc[2*WIDTH-1:WIDTH];
        calc_done <= 1'b1;
      end
    end
  end

endmodule
